// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: controller states, default
// geometry, the fetch buffer entry layout and a saturating-increment helper.
package fetch_ctrl_pkg;

  localparam int unsigned DefDepth  = 4;
  localparam int unsigned DefAddrW  = 64;
  localparam int unsigned DefInstrW = 32;

  typedef enum logic [1:0] {
    StWait     = 2'd0,
    StRun      = 2'd1,
    StRedirect = 2'd2
  } fetch_state_e;

  // Entry layout at the default geometry; the buffer itself stores the two
  // fields in separate arrays so it can follow non-default widths.
  typedef struct packed {
    logic [DefAddrW-1:0]  pc;
    logic [DefInstrW-1:0] instr;
  } fetch_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular in-order FIFO of {pc, instr} pairs between fetch and decode.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   flush_i              drop all entries (pointers and count to zero)
//   push_i, push_pc_i,   write an entry at the tail
//   push_instr_i
//   pop_i                retire the head entry
//   head_pc_o,           head entry, straight from registered storage
//   head_instr_o
//   count_o              number of valid entries (0..DEPTH)
// The caller guarantees no push when full and no pop when empty.
module fetch_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32,
  localparam int unsigned PtrW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [ADDR_W-1:0]  push_pc_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic               pop_i,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [PtrW:0]      count_o
);

  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [ADDR_W-1:0]  pc_d    [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [INSTR_W-1:0] instr_d [DEPTH];
  logic [PtrW-1:0]    head_q, head_d;
  logic [PtrW-1:0]    tail_q, tail_d;
  logic [PtrW:0]      count_q, count_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      // Storage is left alone; only the bookkeeping is cleared.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        pc_d[tail_q]    = push_pc_i;
        instr_d[tail_q] = push_instr_i;
        tail_d          = tail_q + PtrW'(1);
      end
      if (pop_i) begin
        head_d = head_q + PtrW'(1);
      end
      count_d = count_q + {{PtrW{1'b0}}, push_i} - {{PtrW{1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_pc_o    = pc_q[head_q];
  assign head_instr_o = instr_q[head_q];
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. Decides each cycle whether the PC register
// advances, drives the PC restore after a backend mispredict, and buffers
// fetched {pc, instr} pairs for decode behind a valid/ready handshake.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   fetch_address_i, fetch_instruction_i  current PC and its instruction
//   enable_pc_o                         PC register advance enable
//   need_to_restore_o, restore_point_o  PC register loads restore_point_o
//   rob_restore_i, rob_restore_pc_i     mispredict pulse and correct PC
//   decode_valid_o/instr_o/pc_o         buffer head towards decode
//   decode_ready_i                      decode accepts the head
//   stall_count_o                       saturating count of full-buffer RUN cycles
module fetch_sequencer
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned INSTR_W = DefInstrW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  fetch_address_i,
  input  logic [INSTR_W-1:0] fetch_instruction_i,
  output logic               enable_pc_o,
  output logic               need_to_restore_o,
  output logic [ADDR_W-1:0]  restore_point_o,
  input  logic               rob_restore_i,
  input  logic [ADDR_W-1:0]  rob_restore_pc_i,
  output logic               decode_valid_o,
  output logic [INSTR_W-1:0] decode_instr_o,
  output logic [ADDR_W-1:0]  decode_pc_o,
  input  logic               decode_ready_i,
  output logic [31:0]        stall_count_o
);

  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] restore_q, restore_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic [CountW-1:0] count;
  logic              full;
  logic              push;
  logic              pop;

  // Full is judged on the registered count alone, so decode_ready_i never
  // reaches enable_pc_o combinationally.
  assign full = (count == CountW'(DEPTH));
  assign push = (state_q == StRun) && !rob_restore_i && !full;
  // A pop coinciding with a restore is dropped; the flush wins anyway.
  assign pop  = decode_valid_o && decode_ready_i && !rob_restore_i;

  fetch_buffer #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_fetch_buffer (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (rob_restore_i),
    .push_i       (push),
    .push_pc_i    (fetch_address_i),
    .push_instr_i (fetch_instruction_i),
    .pop_i        (pop),
    .head_pc_o    (decode_pc_o),
    .head_instr_o (decode_instr_o),
    .count_o      (count)
  );

  always_comb begin
    state_d     = state_q;
    restore_d   = restore_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      StWait:     state_d = rob_restore_i ? StRedirect : StRun;
      StRun:      state_d = rob_restore_i ? StRedirect : StRun;
      StRedirect: state_d = rob_restore_i ? StRedirect : StRun;
      default:    state_d = StWait;
    endcase

    if (rob_restore_i) begin
      restore_d = rob_restore_pc_i;
    end

    if ((state_q == StRun) && full && !rob_restore_i) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StWait;
      restore_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      restore_q   <= restore_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign enable_pc_o       = push;
  assign need_to_restore_o = (state_q == StRedirect);
  assign restore_point_o   = restore_q;
  assign decode_valid_o    = (count != '0);
  assign stall_count_o     = stall_cnt_q;

endmodule
